// File: rtl/pc_sequencer_if.sv
// Bus between decoder/counter and the PC sequencer.
// Inputs carry decode flags and PC, outputs steer the counter.
interface pc_sequencer_if #(
    parameter int PC_W  = 9,
    parameter int CNT_W = 16
);
    logic             Start;
    logic [PC_W-1:0]  PC;
    logic             IsHalt;
    logic             IsJump;
    logic             IsBr;
    logic             CondTrue;
    logic             IsCall;
    logic             IsRet;
    logic [PC_W-1:0]  Target;
    logic             Init;
    logic             Halt;
    logic             Branch;
    logic [PC_W-1:0]  JP;
    logic             Done;
    logic             Err;
    logic [CNT_W-1:0] Cycles;

    modport master (
        output Start, PC, IsHalt, IsJump, IsBr,
        output CondTrue, IsCall, IsRet, Target,
        input  Init, Halt, Branch, JP, Done, Err, Cycles
    );

    modport slave (
        input  Start, PC, IsHalt, IsJump, IsBr,
        input  CondTrue, IsCall, IsRet, Target,
        output Init, Halt, Branch, JP, Done, Err, Cycles
    );
endinterface

// File: rtl/pc_sequencer.sv
// Control sequencer for the program counter: run FSM,
// call/return stack and saturating RUN-cycle counter.
module pc_sequencer #(
    parameter int PC_W        = 9,
    parameter int STACK_DEPTH = 4,
    parameter int CNT_W       = 16
) (
    input  logic          CLK,
    input  logic          RST_n,
    pc_sequencer_if.slave bus
);
    localparam int AW  = $clog2(STACK_DEPTH);
    localparam int SPW = AW + 1;

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        RUN,
        DONE,
        ERR
    } state_e;

    state_e           state_q, state_d;
    logic [SPW-1:0]   sp_q, sp_d;
    logic [PC_W-1:0]  stack_q [STACK_DEPTH];
    logic [PC_W-1:0]  stack_d [STACK_DEPTH];
    logic [CNT_W-1:0] cycles_q, cycles_d;
    logic             empty;
    logic             full;
    logic [AW-1:0]    push_idx;
    logic [AW-1:0]    top_idx;
    logic             branch;
    logic [PC_W-1:0]  jp;

    assign empty    = (sp_q == '0);
    assign full     = (sp_q == SPW'(STACK_DEPTH));
    assign push_idx = sp_q[AW-1:0];
    assign top_idx  = push_idx - AW'(1);

    // Next state, stack update, cycle count and RUN-cycle steering
    always_comb begin
        state_d  = state_q;
        sp_d     = sp_q;
        stack_d  = stack_q;
        cycles_d = cycles_q;
        branch   = 1'b0;
        jp       = '0;
        case (state_q)
            IDLE, DONE, ERR: begin
                if (bus.Start) state_d = INIT;
            end
            INIT: begin
                cycles_d = '0;
                sp_d     = '0;
                state_d  = RUN;
            end
            RUN: begin
                if (cycles_q != '1) cycles_d = cycles_q + CNT_W'(1);
                priority case (1'b1)
                    bus.IsHalt: state_d = DONE;
                    bus.IsRet: begin
                        if (empty) begin
                            state_d = ERR;
                        end else begin
                            branch = 1'b1;
                            jp     = stack_q[top_idx];
                            sp_d   = sp_q - SPW'(1);
                        end
                    end
                    bus.IsCall: begin
                        if (full) begin
                            state_d = ERR;
                        end else begin
                            branch            = 1'b1;
                            jp                = bus.Target;
                            stack_d[push_idx] = bus.PC + PC_W'(1);
                            sp_d              = sp_q + SPW'(1);
                        end
                    end
                    bus.IsJump: begin
                        branch = 1'b1;
                        jp     = bus.Target;
                    end
                    bus.IsBr: begin
                        branch = bus.CondTrue;
                        jp     = bus.Target;
                    end
                    default: ;
                endcase
            end
            default: state_d = IDLE;
        endcase
    end

    // State, stack and counter registers with async clear
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state_q  <= IDLE;
            sp_q     <= '0;
            cycles_q <= '0;
            for (int i = 0; i < STACK_DEPTH; i++) stack_q[i] <= '0;
        end else begin
            state_q  <= state_d;
            sp_q     <= sp_d;
            cycles_q <= cycles_d;
            for (int i = 0; i < STACK_DEPTH; i++) stack_q[i] <= stack_d[i];
        end
    end

    assign bus.Init   = (state_q == IDLE) || (state_q == INIT);
    assign bus.Halt   = (state_q == DONE) || (state_q == ERR);
    assign bus.Done   = (state_q == DONE);
    assign bus.Err    = (state_q == ERR);
    assign bus.Branch = branch;
    assign bus.JP     = jp;
    assign bus.Cycles = cycles_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: program counter stand-in,
// queue-based reference model, directed and random runs.
module tb_pc_sequencer;
    localparam int PC_W  = 9;
    localparam int DEPTH = 4;
    localparam int CNT_W = 6;
    localparam int CMAX  = (1 << CNT_W) - 1;

    localparam int M_IDLE = 0;
    localparam int M_INIT = 1;
    localparam int M_RUN  = 2;
    localparam int M_DONE = 3;
    localparam int M_ERR  = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    pc_sequencer_if #(.PC_W(PC_W), .CNT_W(CNT_W)) bus ();

    pc_sequencer #(
        .PC_W(PC_W),
        .STACK_DEPTH(DEPTH),
        .CNT_W(CNT_W)
    ) dut (
        .CLK(clk),
        .RST_n(rst_n),
        .bus(bus.slave)
    );

    // Program counter driven by the sequencer outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          bus.PC <= '0;
        else if (bus.Init)   bus.PC <= '0;
        else if (bus.Halt)   bus.PC <= bus.PC;
        else if (bus.Branch) bus.PC <= bus.JP;
        else                 bus.PC <= bus.PC + PC_W'(1);
    end

    int n_cmp = 0;
    int n_bad = 0;

    int              m_st;
    logic [PC_W-1:0] m_stk[$];
    int              m_cyc;

    logic            e_init, e_halt, e_br, e_done, e_err;
    logic [PC_W-1:0] e_jp;
    logic            last_br;
    logic [PC_W-1:0] last_jp;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_st  = M_IDLE;
        m_stk.delete();
        m_cyc = 0;
    endtask

    task automatic predict();
        e_init = (m_st == M_IDLE) || (m_st == M_INIT);
        e_halt = (m_st == M_DONE) || (m_st == M_ERR);
        e_done = (m_st == M_DONE);
        e_err  = (m_st == M_ERR);
        e_br   = 1'b0;
        e_jp   = '0;
        if (m_st == M_RUN) begin
            if (bus.IsHalt) begin
                e_br = 1'b0;
            end else if (bus.IsRet) begin
                if (m_stk.size() > 0) begin
                    e_br = 1'b1;
                    e_jp = m_stk[$];
                end
            end else if (bus.IsCall) begin
                if (m_stk.size() < DEPTH) begin
                    e_br = 1'b1;
                    e_jp = bus.Target;
                end
            end else if (bus.IsJump) begin
                e_br = 1'b1;
                e_jp = bus.Target;
            end else if (bus.IsBr) begin
                e_br = bus.CondTrue;
                e_jp = bus.Target;
            end
        end
    endtask

    task automatic advance();
        logic [PC_W-1:0] ret_addr;
        ret_addr = bus.PC + PC_W'(1);
        case (m_st)
            M_IDLE, M_DONE, M_ERR: if (bus.Start) m_st = M_INIT;
            M_INIT: begin
                m_st  = M_RUN;
                m_cyc = 0;
                m_stk.delete();
            end
            default: begin
                if (m_cyc < CMAX) m_cyc++;
                if (bus.IsHalt) begin
                    m_st = M_DONE;
                end else if (bus.IsRet) begin
                    if (m_stk.size() > 0) void'(m_stk.pop_back());
                    else m_st = M_ERR;
                end else if (bus.IsCall) begin
                    if (m_stk.size() < DEPTH) m_stk.push_back(ret_addr);
                    else m_st = M_ERR;
                end
            end
        endcase
    endtask

    task automatic drive(input logic st, input logic h, input logic r,
                         input logic c, input logic j, input logic b,
                         input logic ct, input logic [PC_W-1:0] tg);
        bus.Start    = st;
        bus.IsHalt   = h;
        bus.IsRet    = r;
        bus.IsCall   = c;
        bus.IsJump   = j;
        bus.IsBr     = b;
        bus.CondTrue = ct;
        bus.Target   = tg;
    endtask

    // one clock: drive, compare against model, advance model
    task automatic step(input logic st, input logic h, input logic r,
                        input logic c, input logic j, input logic b,
                        input logic ct, input logic [PC_W-1:0] tg);
        @(negedge clk);
        drive(st, h, r, c, j, b, ct, tg);
        #1;
        predict();
        last_br = bus.Branch;
        last_jp = bus.JP;
        chk("init", bus.Init, e_init);
        chk("halt", bus.Halt, e_halt);
        chk("branch", bus.Branch, e_br);
        chk("jp", bus.JP, e_jp);
        chk("done", bus.Done, e_done);
        chk("err", bus.Err, e_err);
        chk("cycles", bus.Cycles, m_cyc);
        advance();
        @(posedge clk);
        #1;
    endtask

    task automatic nop();
        step(0, 0, 0, 0, 0, 0, 0, '0);
    endtask

    task automatic start_run();
        step(1, 0, 0, 0, 0, 0, 0, '0);
        nop();
    endtask

    logic [PC_W-1:0] pc_hold;

    initial begin
        drive(0, 0, 0, 0, 0, 0, 0, '0);
        model_reset();
        #1;
        chk("rst_init", bus.Init, 1);
        chk("rst_halt", bus.Halt, 0);
        chk("rst_branch", bus.Branch, 0);
        chk("rst_jp", bus.JP, 0);
        chk("rst_done", bus.Done, 0);
        chk("rst_err", bus.Err, 0);
        chk("rst_cycles", bus.Cycles, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // basic run, halt at PC=3
        nop();
        nop();
        start_run();
        chk("run_init_low", bus.Init, 0);
        for (int i = 0; i < 3; i++) begin
            chk("count_pc", bus.PC, i);
            nop();
        end
        chk("count_pc3", bus.PC, 3);
        step(0, 1, 0, 0, 0, 0, 0, '0);
        chk("halt_done", bus.Done, 1);
        chk("halt_cycles", bus.Cycles, 4);
        pc_hold = bus.PC;
        nop();
        chk("halt_pc_hold", bus.PC, pc_hold);

        // priority jump over not-taken branch
        start_run();
        step(0, 0, 0, 0, 1, 1, 0, 9'h1A5);
        chk("prio_br", last_br, 1);
        chk("prio_jp", last_jp, 9'h1A5);
        chk("prio_pc", bus.PC, 9'h1A5);

        // call at PC wrap boundary, then return
        step(0, 0, 0, 0, 1, 0, 0, 9'h1FF);
        chk("wrap_pc", bus.PC, 9'h1FF);
        step(0, 0, 0, 1, 0, 0, 0, 9'h010);
        chk("wrap_call_jp", last_jp, 9'h010);
        nop();
        step(0, 0, 1, 0, 0, 0, 0, 9'h0AA);
        chk("wrap_ret_br", last_br, 1);
        chk("wrap_ret_jp", last_jp, 9'h000);
        chk("wrap_ret_pc", bus.PC, 9'h000);
        step(0, 1, 0, 0, 0, 0, 0, '0);

        // nested overflow
        start_run();
        for (int i = 0; i < DEPTH; i++) begin
            step(0, 0, 0, 1, 0, 0, 0, PC_W'(16 * (i + 1)));
            chk("ovf_call_br", last_br, 1);
        end
        step(0, 0, 0, 1, 0, 0, 0, 9'h100);
        chk("ovf_br", last_br, 0);
        chk("ovf_err", bus.Err, 1);
        chk("ovf_halt", bus.Halt, 1);
        start_run();
        chk("restart_err", bus.Err, 0);

        // underflow as first instruction
        step(0, 0, 1, 0, 0, 0, 0, '0);
        chk("unf_br", last_br, 0);
        chk("unf_err", bus.Err, 1);
        chk("unf_done", bus.Done, 0);

        // async reset mid-run at PC=7 with two entries
        start_run();
        step(0, 0, 0, 1, 0, 0, 0, 9'h005);
        step(0, 0, 0, 1, 0, 0, 0, 9'h006);
        nop();
        chk("pre_rst_pc", bus.PC, 7);
        @(negedge clk);
        drive(0, 0, 0, 0, 1, 0, 0, 9'h033);
        #1;
        chk("pre_rst_br", bus.Branch, 1);
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("arst_init", bus.Init, 1);
        chk("arst_br", bus.Branch, 0);
        chk("arst_jp", bus.JP, 0);
        chk("arst_cycles", bus.Cycles, 0);
        drive(0, 0, 0, 0, 0, 0, 0, '0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        nop();
        start_run();
        step(0, 0, 1, 0, 0, 0, 0, '0);
        chk("arst_unf_err", bus.Err, 1);

        // cycle counter saturation
        start_run();
        for (int i = 0; i < CMAX + 8; i++) nop();
        chk("sat_cycles", bus.Cycles, CMAX);
        step(0, 1, 0, 0, 0, 0, 0, '0);
        chk("sat_hold", bus.Cycles, CMAX);

        // randomized instruction streams
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 40) == 0),
                 ($urandom_range(0, 5) == 0),
                 ($urandom_range(0, 5) == 0),
                 ($urandom_range(0, 6) == 0),
                 ($urandom_range(0, 4) == 0),
                 1'($urandom_range(0, 1)),
                 PC_W'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule
